// File: rtl/flagunit.sv
// flagunit: NZCV flag producer and architectural flag holder.
//
// Computes the ALU result and N/Z/C/V for the Execute-stage operation. It commits
// the flags into the architectural register under per-group write enables, gated by
// the instruction's condition-pass. It also keeps a shadow copy of the flags for
// exception entry and return.
//
// Ports:
//   clk, reset     clock; synchronous active-high reset
//   SrcA, SrcB     ALU operands (SrcB already shifted)
//   ALUControl     00 ADD, 01 SUB, 10 AND, 11 ORR
//   ShiftCarry     shifter carry-out, used as C for logical ops
//   ValidE, StallE, FlushE, CondExE   Execute-stage commit qualifiers
//   FlagWriteE     bit1 writes N,Z; bit0 writes C,V
//   ExcEntry       save Flags into the shadow register
//   ExcReturn      restore Flags from the shadow register (beats a commit)
//   Result         combinational ALU result
//   Flags          registered {N,Z,C,V}
//   SavedFlags     registered shadow {N,Z,C,V}
//   FlagUpd        registered pulse: an instruction wrote flags last cycle
module flagunit #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] SrcA,
  input  logic [WIDTH-1:0] SrcB,
  input  logic [1:0]       ALUControl,
  input  logic             ShiftCarry,
  input  logic             ValidE,
  input  logic             StallE,
  input  logic             FlushE,
  input  logic             CondExE,
  input  logic [1:0]       FlagWriteE,
  input  logic             ExcEntry,
  input  logic             ExcReturn,
  output logic [WIDTH-1:0] Result,
  output logic [3:0]       Flags,
  output logic [3:0]       SavedFlags,
  output logic             FlagUpd
);

  localparam int unsigned EXT_W = WIDTH + 1;
  localparam int unsigned MSB   = WIDTH - 1;

  // Flag vector bit positions
  localparam int unsigned N_BIT = 3;
  localparam int unsigned Z_BIT = 2;
  localparam int unsigned C_BIT = 1;
  localparam int unsigned V_BIT = 0;

  localparam logic [1:0] OP_ADD = 2'b00;
  localparam logic [1:0] OP_SUB = 2'b01;
  localparam logic [1:0] OP_AND = 2'b10;
  localparam logic [1:0] OP_ORR = 2'b11;

  logic [3:0]       flags_q, flags_d;
  logic [3:0]       saved_q, saved_d;
  logic             upd_q, upd_d;

  logic [WIDTH-1:0] b_op;
  logic             carry_in;
  logic [EXT_W-1:0] sum_ext;
  logic [WIDTH-1:0] result_c;
  logic             n_c, z_c, c_c, v_c;
  logic             commit_c;

  // Shared adder: SUB is A + ~B + 1, so its carry-out means "no borrow"
  always_comb begin
    b_op     = SrcB;
    carry_in = 1'b0;
    if (ALUControl == OP_SUB) begin
      b_op     = ~SrcB;
      carry_in = 1'b1;
    end
    sum_ext = EXT_W'(SrcA) + EXT_W'(b_op) + EXT_W'(carry_in);
  end

  // Result and flag computation for the current operation
  always_comb begin
    result_c = sum_ext[WIDTH-1:0];
    c_c      = sum_ext[WIDTH];
    v_c      = 1'b0;
    case (ALUControl)
      OP_ADD: begin
        result_c = sum_ext[WIDTH-1:0];
        c_c      = sum_ext[WIDTH];
        v_c      = (SrcA[MSB] == SrcB[MSB]) & (result_c[MSB] != SrcA[MSB]);
      end
      OP_SUB: begin
        result_c = sum_ext[WIDTH-1:0];
        c_c      = sum_ext[WIDTH];
        v_c      = (SrcA[MSB] != SrcB[MSB]) & (result_c[MSB] != SrcA[MSB]);
      end
      OP_AND: begin
        result_c = SrcA & SrcB;
        c_c      = ShiftCarry;
        v_c      = flags_q[V_BIT];
      end
      OP_ORR: begin
        result_c = SrcA | SrcB;
        c_c      = ShiftCarry;
        v_c      = flags_q[V_BIT];
      end
      default: begin
        result_c = sum_ext[WIDTH-1:0];
        c_c      = sum_ext[WIDTH];
        v_c      = 1'b0;
      end
    endcase
    n_c = result_c[MSB];
    z_c = (result_c == '0);
  end

  assign commit_c = ValidE & CondExE & ~StallE & ~FlushE;

  // Next-state: group-enabled commit, then exception restore overrides it
  always_comb begin
    flags_d = flags_q;
    saved_d = saved_q;
    upd_d   = 1'b0;

    if (commit_c && FlagWriteE[1]) begin
      flags_d[N_BIT] = n_c;
      flags_d[Z_BIT] = z_c;
    end
    if (commit_c && FlagWriteE[0]) begin
      flags_d[C_BIT] = c_c;
      flags_d[V_BIT] = v_c;
    end

    // Both use pre-update values, so entry+return swaps the two registers
    if (ExcEntry) begin
      saved_d = flags_q;
    end
    if (ExcReturn) begin
      flags_d = saved_q;
    end

    upd_d = commit_c & (|FlagWriteE) & ~ExcReturn;
  end

  // State registers
  always_ff @(posedge clk) begin
    if (reset) begin
      flags_q <= 4'b0000;
      saved_q <= 4'b0000;
      upd_q   <= 1'b0;
    end else begin
      flags_q <= flags_d;
      saved_q <= saved_d;
      upd_q   <= upd_d;
    end
  end

  assign Result     = result_c;
  assign Flags      = flags_q;
  assign SavedFlags = saved_q;
  assign FlagUpd    = upd_q;

endmodule

// File: tb/tb_flagunit.sv
// tb_flagunit: directed self-checking bench for flagunit (WIDTH = 32).
module tb_flagunit;

  localparam int unsigned W = 32;

  logic          clk;
  logic          reset;
  logic [W-1:0]  SrcA, SrcB;
  logic [1:0]    ALUControl;
  logic          ShiftCarry;
  logic          ValidE, StallE, FlushE, CondExE;
  logic [1:0]    FlagWriteE;
  logic          ExcEntry, ExcReturn;
  logic [W-1:0]  Result;
  logic [3:0]    Flags, SavedFlags;
  logic          FlagUpd;

  int checks   = 0;
  int failures = 0;

  flagunit #(.WIDTH(W)) dut (
    .clk        (clk),
    .reset      (reset),
    .SrcA       (SrcA),
    .SrcB       (SrcB),
    .ALUControl (ALUControl),
    .ShiftCarry (ShiftCarry),
    .ValidE     (ValidE),
    .StallE     (StallE),
    .FlushE     (FlushE),
    .CondExE    (CondExE),
    .FlagWriteE (FlagWriteE),
    .ExcEntry   (ExcEntry),
    .ExcReturn  (ExcReturn),
    .Result     (Result),
    .Flags      (Flags),
    .SavedFlags (SavedFlags),
    .FlagUpd    (FlagUpd)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Inputs change 1 time unit after the rising edge; outputs are sampled there too
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    reset      = 1'b0;
    ValidE     = 1'b0;
    StallE     = 1'b0;
    FlushE     = 1'b0;
    CondExE    = 1'b0;
    FlagWriteE = 2'b00;
    ExcEntry   = 1'b0;
    ExcReturn  = 1'b0;
    ShiftCarry = 1'b0;
    ALUControl = 2'b00;
    SrcA       = '0;
    SrcB       = '0;
  endtask

  // Sets up a committing instruction (valid, cond pass, no stall/flush)
  task automatic set_op(input logic [1:0] op, input logic [W-1:0] a,
                        input logic [W-1:0] b, input logic [1:0] fw);
    idle();
    ALUControl = op;
    SrcA       = a;
    SrcB       = b;
    ValidE     = 1'b1;
    CondExE    = 1'b1;
    FlagWriteE = fw;
  endtask

  task automatic test_reset();
    reset      = 1'b1;
    SrcA       = $urandom;
    SrcB       = $urandom;
    ALUControl = 2'($urandom_range(0, 3));
    ShiftCarry = 1'($urandom_range(0, 1));
    ValidE     = 1'b1;
    CondExE    = 1'b1;
    StallE     = 1'b0;
    FlushE     = 1'b0;
    FlagWriteE = 2'b11;
    ExcEntry   = 1'b1;
    ExcReturn  = 1'b0;
    tick();
    tick();
    checks++;
    if (Flags !== 4'b0000) begin
      failures++;
      $display("FAIL reset_flags got=%b exp=0000", Flags);
    end
    checks++;
    if (SavedFlags !== 4'b0000) begin
      failures++;
      $display("FAIL reset_saved got=%b exp=0000", SavedFlags);
    end
    checks++;
    if (FlagUpd !== 1'b0) begin
      failures++;
      $display("FAIL reset_upd got=%b exp=0", FlagUpd);
    end
    idle();
    tick();
  endtask

  // ADD then ADD back-to-back; FlagUpd must stay high across both
  task automatic test_add();
    set_op(2'b00, 32'h7FFF_FFFF, 32'h0000_0001, 2'b11);
    #1;
    checks++;
    if (Result !== 32'h8000_0000) begin
      failures++;
      $display("FAIL add_ovf_result got=%h exp=80000000", Result);
    end
    tick();
    checks++;
    if (Flags !== 4'b1001) begin
      failures++;
      $display("FAIL add_ovf_flags got=%b exp=1001", Flags);
    end
    checks++;
    if (FlagUpd !== 1'b1) begin
      failures++;
      $display("FAIL add_ovf_upd got=%b exp=1", FlagUpd);
    end
    set_op(2'b00, 32'hFFFF_FFFF, 32'h0000_0001, 2'b11);
    #1;
    checks++;
    if (Result !== 32'h0000_0000) begin
      failures++;
      $display("FAIL add_wrap_result got=%h exp=00000000", Result);
    end
    tick();
    checks++;
    if (Flags !== 4'b0110) begin
      failures++;
      $display("FAIL add_wrap_flags got=%b exp=0110", Flags);
    end
    checks++;
    if (FlagUpd !== 1'b1) begin
      failures++;
      $display("FAIL back_to_back_upd got=%b exp=1", FlagUpd);
    end
    idle();
    tick();
    checks++;
    if (FlagUpd !== 1'b0) begin
      failures++;
      $display("FAIL upd_drop got=%b exp=0", FlagUpd);
    end
  endtask

  task automatic test_sub();
    set_op(2'b01, 32'd5, 32'd5, 2'b11);
    tick();
    checks++;
    if (Flags !== 4'b0110) begin
      failures++;
      $display("FAIL sub_eq_flags got=%b exp=0110", Flags);
    end
    set_op(2'b01, 32'd3, 32'd5, 2'b11);
    #1;
    checks++;
    if (Result !== 32'hFFFF_FFFE) begin
      failures++;
      $display("FAIL sub_neg_result got=%h exp=fffffffe", Result);
    end
    tick();
    checks++;
    if (Flags !== 4'b1000) begin
      failures++;
      $display("FAIL sub_neg_flags got=%b exp=1000", Flags);
    end
    set_op(2'b01, 32'h8000_0000, 32'h0000_0001, 2'b11);
    #1;
    checks++;
    if (Result !== 32'h7FFF_FFFF) begin
      failures++;
      $display("FAIL sub_ovf_result got=%h exp=7fffffff", Result);
    end
    tick();
    checks++;
    if (Flags !== 4'b0011) begin
      failures++;
      $display("FAIL sub_ovf_flags got=%b exp=0011", Flags);
    end
    idle();
    tick();
  endtask

  // Each blocking qualifier alone must suppress the commit of ADD 1+1 (-> 0000)
  task automatic test_gating();
    set_op(2'b00, 32'hFFFF_FFFF, 32'h1, 2'b11);
    tick();
    for (int k = 0; k < 4; k++) begin
      set_op(2'b00, 32'd1, 32'd1, 2'b11);
      case (k)
        0: CondExE = 1'b0;
        1: FlushE  = 1'b1;
        2: StallE  = 1'b1;
        default: ValidE = 1'b0;
      endcase
      tick();
      checks++;
      if (Flags !== 4'b0110 || FlagUpd !== 1'b0) begin
        failures++;
        $display("FAIL gate_%0d flags=%b upd=%b exp flags=0110 upd=0", k, Flags, FlagUpd);
      end
    end
    set_op(2'b00, 32'd1, 32'd1, 2'b10);
    tick();
    checks++;
    if (Flags !== 4'b0010) begin
      failures++;
      $display("FAIL gate_nz_only got=%b exp=0010", Flags);
    end
    idle();
    tick();
  endtask

  // Held stall: no commit until StallE drops, then exactly one
  task automatic test_stall_hold();
    set_op(2'b01, 32'd3, 32'd5, 2'b11);
    StallE = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++;
      if (Flags !== 4'b0010 || FlagUpd !== 1'b0) begin
        failures++;
        $display("FAIL stall_hold_%0d flags=%b upd=%b exp flags=0010 upd=0", i, Flags, FlagUpd);
      end
    end
    StallE = 1'b0;
    tick();
    checks++;
    if (Flags !== 4'b1000 || FlagUpd !== 1'b1) begin
      failures++;
      $display("FAIL stall_release flags=%b upd=%b exp flags=1000 upd=1", Flags, FlagUpd);
    end
    idle();
    tick();
    checks++;
    if (FlagUpd !== 1'b0) begin
      failures++;
      $display("FAIL stall_single_upd got=%b exp=0", FlagUpd);
    end
  endtask

  task automatic test_logical();
    // Reach 0001: from 1000, write N,Z from 0 AND 0 -> N0 Z1; then C,V from overflowing ADD
    set_op(2'b10, 32'h0, 32'h0, 2'b10);
    tick();
    set_op(2'b00, 32'h7FFF_FFFF, 32'h1, 2'b01);
    tick();
    set_op(2'b00, 32'h1, 32'h1, 2'b10);
    tick();
    checks++;
    if (Flags !== 4'b0001) begin
      failures++;
      $display("FAIL logical_setup got=%b exp=0001", Flags);
    end
    set_op(2'b11, 32'h0, 32'h0, 2'b11);
    ShiftCarry = 1'b1;
    tick();
    checks++;
    if (Flags !== 4'b0111) begin
      failures++;
      $display("FAIL orr_keep_v got=%b exp=0111", Flags);
    end
    set_op(2'b10, 32'hF0F0_F0F0, 32'hFF00_FF00, 2'b11);
    ShiftCarry = 1'b0;
    #1;
    checks++;
    if (Result !== 32'hF000_F000) begin
      failures++;
      $display("FAIL and_result got=%h exp=f000f000", Result);
    end
    tick();
    checks++;
    if (Flags !== 4'b1001) begin
      failures++;
      $display("FAIL and_flags got=%b exp=1001", Flags);
    end
    idle();
    tick();
  endtask

  task automatic test_exception();
    // FFFFFFFF + FFFFFFFF -> N1 Z0 C1 V0
    set_op(2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 2'b11);
    tick();
    checks++;
    if (Flags !== 4'b1010) begin
      failures++;
      $display("FAIL exc_setup got=%b exp=1010", Flags);
    end
    idle();
    ExcEntry = 1'b1;
    tick();
    checks++;
    if (SavedFlags !== 4'b1010) begin
      failures++;
      $display("FAIL exc_entry_saved got=%b exp=1010", SavedFlags);
    end
    set_op(2'b00, 32'hFFFF_FFFF, 32'h1, 2'b11);
    tick();
    checks++;
    if (Flags !== 4'b0110) begin
      failures++;
      $display("FAIL exc_commit got=%b exp=0110", Flags);
    end
    set_op(2'b01, 32'd3, 32'd5, 2'b11);
    ExcReturn = 1'b1;
    tick();
    checks++;
    if (Flags !== 4'b1010 || FlagUpd !== 1'b0) begin
      failures++;
      $display("FAIL exc_return flags=%b upd=%b exp flags=1010 upd=0", Flags, FlagUpd);
    end
    set_op(2'b00, 32'hFFFF_FFFF, 32'h1, 2'b11);
    tick();
    idle();
    ExcEntry  = 1'b1;
    ExcReturn = 1'b1;
    StallE    = 1'b1;
    tick();
    checks++;
    if (Flags !== 4'b1010 || SavedFlags !== 4'b0110) begin
      failures++;
      $display("FAIL exc_swap flags=%b saved=%b exp flags=1010 saved=0110", Flags, SavedFlags);
    end
    idle();
    tick();
  endtask

  // Reset mid-stream discards same-cycle commit and exception actions
  task automatic test_reset_midstream();
    set_op(2'b00, 32'h7FFF_FFFF, 32'h1, 2'b11);
    ExcEntry = 1'b1;
    reset    = 1'b1;
    tick();
    checks++;
    if (Flags !== 4'b0000 || SavedFlags !== 4'b0000 || FlagUpd !== 1'b0) begin
      failures++;
      $display("FAIL reset_mid flags=%b saved=%b upd=%b exp 0000 0000 0", Flags, SavedFlags, FlagUpd);
    end
    idle();
    tick();
  endtask

  initial begin
    idle();
    #1;
    test_reset();
    test_add();
    test_sub();
    test_gating();
    test_stall_hold();
    test_logical();
    test_exception();
    test_reset_midstream();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
